// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter stage of the single-cycle core.
// Holds the PC and resolves j/jal/jr/bne/blt/bex redirects from a one-hot decode.
//
// Ports:
//   clock, reset      - rising-edge clock, async active-high reset
//   ctrl[10:0]        - one-hot decode {setx,bex,blt,jr,jal,bne,j,R,addi,sw,lw}
//   imm[16:0]         - signed I-type immediate
//   target[26:0]      - JI-type target
//   alu_ne, alu_lt    - branch compare results from the ALU
//   rd_val[31:0]      - register value used by jr
//   rstatus_nz        - $rstatus != 0, used by bex
//   stall             - mult/div busy, PC must hold
//   pc_out            - registered PC (imem address)
//   pc_plus1          - pc_out + 1, also the jal link value
//   fetch_valid       - instruction at pc_out may retire this cycle
//   taken             - a redirect is selected this cycle
//   ctrl_err          - more than one ctrl bit set this cycle

module pc_sequencer #(
    parameter int          PC_WIDTH = 12,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [10:0]         ctrl,
    input  logic [16:0]         imm,
    input  logic [26:0]         target,
    input  logic                alu_ne,
    input  logic                alu_lt,
    input  logic [31:0]         rd_val,
    input  logic                rstatus_nz,
    input  logic                stall,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic [PC_WIDTH-1:0] pc_plus1,
    output logic                fetch_valid,
    output logic                taken,
    output logic                ctrl_err
);

    // Decode bit positions.
    localparam int C_J    = 4;
    localparam int C_BNE  = 5;
    localparam int C_JAL  = 6;
    localparam int C_JR   = 7;
    localparam int C_BLT  = 8;
    localparam int C_BEX  = 9;

    // FSM encoding.
    localparam logic [1:0] S_BOOT = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_HOLD = 2'b10;

    // Branch adder width: wide enough for both the PC and the 17-bit
    // immediate plus one guard bit, then truncated back to PC_WIDTH.
    localparam int XW = ((PC_WIDTH > 17) ? PC_WIDTH : 17) + 1;

    logic [1:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;

    logic                active;
    logic                multi_hot;
    logic                legal;

    logic                do_jump;
    logic                do_jr;
    logic                do_br;
    logic                redirect;

    logic [XW-1:0]       imm_ext;
    logic [XW-1:0]       pc1_ext;
    logic [XW-1:0]       br_sum;
    logic [PC_WIDTH-1:0] br_target;
    logic [PC_WIDTH-1:0] next_pc;

    logic                unused_bits;

    // ------------------------------------------------------------------
    // Decode qualification
    // ------------------------------------------------------------------

    // x & (x-1) clears the lowest set bit; anything left means >1 bit set.
    assign multi_hot = |(ctrl & (ctrl - 11'd1));
    assign legal     = ~multi_hot;

    // ctrl is only meaningful once the boot cycle has passed.
    assign active = (state_q == S_RUN) || (state_q == S_HOLD);

    assign pc_plus1 = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Branch target: pc + 1 + sext(imm), modulo 2^PC_WIDTH
    // ------------------------------------------------------------------

    assign imm_ext   = {{(XW-17){imm[16]}}, imm};
    assign pc1_ext   = {{(XW-PC_WIDTH){1'b0}}, pc_plus1};
    assign br_sum    = pc1_ext + imm_ext;
    assign br_target = br_sum[PC_WIDTH-1:0];

    // ------------------------------------------------------------------
    // Redirect selection
    // ------------------------------------------------------------------

    always_comb begin
        do_jump = 1'b0;
        do_jr   = 1'b0;
        do_br   = 1'b0;
        if (legal) begin
            do_jump = ctrl[C_J] | ctrl[C_JAL] | (ctrl[C_BEX] & rstatus_nz);
            do_jr   = ctrl[C_JR];
            do_br   = (ctrl[C_BNE] & alu_ne) | (ctrl[C_BLT] & alu_lt);
        end
    end

    assign redirect = do_jump | do_jr | do_br;

    always_comb begin
        next_pc = pc_plus1;
        unique case (1'b1)
            do_jump: next_pc = target[PC_WIDTH-1:0];
            do_jr:   next_pc = rd_val[PC_WIDTH-1:0];
            do_br:   next_pc = br_target;
            default: next_pc = pc_plus1;
        endcase
    end

    // ------------------------------------------------------------------
    // Boot / run / hold sequencing
    // ------------------------------------------------------------------

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (stall) begin
                    state_d = S_HOLD;
                end else begin
                    pc_d = next_pc;
                end
            end
            S_HOLD: begin
                // Operands are held stable upstream, so the redirect
                // resolved now is the one for the stalled instruction.
                if (!stall) begin
                    state_d = S_RUN;
                    pc_d    = next_pc;
                end
            end
            default: begin
                state_d = S_BOOT;
                pc_d    = RESET_PC;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    assign pc_out      = pc_q;
    assign fetch_valid = (state_q == S_RUN);
    assign taken       = active & redirect;
    assign ctrl_err    = active & multi_hot;

    assign unused_bits = ^{target, rd_val, br_sum};

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed test of the PC stage.
// Vectors with hand-computed expected PCs and flags.

module tb_pc_sequencer;

    logic        clock;
    logic        reset;
    logic [10:0] ctrl;
    logic [16:0] imm;
    logic [26:0] target;
    logic        alu_ne;
    logic        alu_lt;
    logic [31:0] rd_val;
    logic        rstatus_nz;
    logic        stall;
    logic [11:0] pc_out;
    logic [11:0] pc_plus1;
    logic        fetch_valid;
    logic        taken;
    logic        ctrl_err;

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer #(
        .PC_WIDTH (12),
        .RESET_PC (12'd0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ctrl        (ctrl),
        .imm         (imm),
        .target      (target),
        .alu_ne      (alu_ne),
        .alu_lt      (alu_lt),
        .rd_val      (rd_val),
        .rstatus_nz  (rstatus_nz),
        .stall       (stall),
        .pc_out      (pc_out),
        .pc_plus1    (pc_plus1),
        .fetch_valid (fetch_valid),
        .taken       (taken),
        .ctrl_err    (ctrl_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     tag, obs, obs, exp, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Jump to an absolute PC using j, leaving ctrl at R-type.
    task automatic goto_pc(input logic [11:0] pc);
        ctrl   = 11'h010;
        target = {15'd0, pc};
        step();
        ctrl   = 11'h008;
    endtask

    initial begin
        reset      = 1'b1;
        ctrl       = 11'h000;
        imm        = '0;
        target     = '0;
        alu_ne     = 1'b0;
        alu_lt     = 1'b0;
        rd_val     = '0;
        rstatus_nz = 1'b0;
        stall      = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_pc",    pc_out,      0);
        check("rst_pc1",   pc_plus1,    1);
        check("rst_fv",    fetch_valid, 0);
        check("rst_taken", taken,       0);
        check("rst_err",   ctrl_err,    0);

        // Boot then sequential: 0,0,1,2,3
        reset = 1'b0;
        ctrl  = 11'h008;
        #1;
        check("boot_pc", pc_out,      0);
        check("boot_fv", fetch_valid, 0);
        step();
        check("run0_pc", pc_out,      0);
        check("run0_fv", fetch_valid, 1);
        step();
        check("seq1", pc_out, 1);
        step();
        check("seq2", pc_out, 2);
        step();
        check("seq3", pc_out, 3);

        // Wrap 4094 -> 4095 -> 0
        goto_pc(12'd4094);
        check("wrap_a", pc_out, 4094);
        step();
        check("wrap_b",   pc_out,   4095);
        check("wrap_p1",  pc_plus1, 0);
        step();
        check("wrap_c",   pc_out,   0);
        check("wrap_err", ctrl_err, 0);

        // bne taken, offset -5 from PC 20
        goto_pc(12'd20);
        ctrl   = 11'h020;
        alu_ne = 1'b1;
        imm    = 17'h1FFFB;
        #1;
        check("bne_t_tk", taken, 1);
        step();
        check("bne_t_pc", pc_out, 16);

        // Same branch, not taken
        goto_pc(12'd20);
        ctrl   = 11'h020;
        alu_ne = 1'b0;
        #1;
        check("bne_n_tk", taken, 0);
        step();
        check("bne_n_pc", pc_out, 21);

        // blt taken, +16 from PC 21 -> 38
        ctrl   = 11'h100;
        alu_lt = 1'b1;
        imm    = 17'h00010;
        #1;
        check("blt_tk", taken, 1);
        step();
        check("blt_pc", pc_out, 38);
        alu_lt = 1'b0;

        // jal then jr
        goto_pc(12'd7);
        ctrl   = 11'h040;
        target = 27'h100;
        #1;
        check("jal_p1", pc_plus1, 8);
        check("jal_tk", taken,    1);
        step();
        check("jal_pc", pc_out, 12'h100);
        ctrl   = 11'h080;
        rd_val = 32'd8;
        step();
        check("jr_pc", pc_out, 8);

        // Stall three edges with bex pending at PC 30
        goto_pc(12'd30);
        ctrl       = 11'h200;
        rstatus_nz = 1'b1;
        target     = 27'h55;
        stall      = 1'b1;
        #1;
        check("bex_run_fv", fetch_valid, 1);
        check("bex_tk",     taken,       1);
        step();
        check("hold1_pc", pc_out,      30);
        check("hold1_fv", fetch_valid, 0);
        check("hold_tk",  taken,       1);
        step();
        step();
        check("hold3_pc", pc_out,      30);
        check("hold3_fv", fetch_valid, 0);
        stall = 1'b0;
        step();
        check("bex_pc", pc_out,      12'h55);
        check("bex_fv", fetch_valid, 1);

        // bex not taken with rstatus zero
        rstatus_nz = 1'b0;
        #1;
        check("bex_n_tk", taken, 0);
        step();
        check("bex_n_pc", pc_out, 12'h56);

        // One-cycle stall pulse costs one cycle
        ctrl  = 11'h008;
        stall = 1'b1;
        step();
        stall = 1'b0;
        check("pulse_hold", pc_out, 12'h56);
        step();
        check("pulse_pc", pc_out, 12'h57);

        // Illegal ctrl at PC 9
        goto_pc(12'd9);
        ctrl   = 11'h030;
        alu_ne = 1'b1;
        target = 27'h77;
        #1;
        check("ill_err", ctrl_err, 1);
        check("ill_tk",  taken,    0);
        step();
        check("ill_pc",  pc_out,   10);
        alu_ne = 1'b0;

        // Async reset pulse between edges, redirect pending
        ctrl   = 11'h010;
        target = 27'h200;
        #2;
        reset = 1'b1;
        #1;
        check("ar_pc",  pc_out,      0);
        check("ar_fv",  fetch_valid, 0);
        check("ar_tk",  taken,       0);
        reset = 1'b0;
        step();
        check("ar_boot_pc", pc_out, 0);
        step();
        check("ar_run_pc", pc_out, 12'h200);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
